wr_ptr_full_ctrl: RTL

Write-domain pointer and status controller for the dual-clock FIFO. It is the write-side counterpart of the read pointer/empty logic. It advances a binary/Gray write pointer and synchronises the read Gray pointer into the write clock. It generates registered full, almost-full, fill-level and overflow status. It sits between the FIFO write port, the dual-port RAM write address/enable, and the read-domain pointer logic.

---
 rtl/async_fifo_pkg.sv | 22 ++
 rtl/ptr_sync.sv | 34 +++
 rtl/wr_ptr_full_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared Gray/binary helpers and defaults for the dual-clock FIFO
package async_fifo_pkg;

   localparam int DEFAULT_ADDR_WIDTH  = 4;
   localparam int DEFAULT_SYNC_STAGES = 2;
   localparam int PTR_MAX_W           = 32;

   // Callers zero-extend into PTR_MAX_W and size-cast the result back to their own width.
   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
      logic [PTR_MAX_W-1:0] bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// rtl/ptr_sync.sv - multi-flop synchroniser for a Gray pointer crossing into the local clock
module ptr_sync
   import async_fifo_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_ADDR_WIDTH + 1,
   parameter int STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];

   always_comb begin
      sync_d[0] = d_i;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= sync_d[i];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// rtl/wr_ptr_full_ctrl.sv - write-domain pointer, full/almost-full/level/overflow status
// Optional sticky overflow register built when WR_PTR_FULL_OVERFLOW_EN is defined.
module wr_ptr_full_ctrl
   import async_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                  wr_clk_i,
   input  logic                  wr_arstn_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH:0]   rd_ptr_i,
   input  logic [ADDR_WIDTH:0]   afull_thresh_i,
   input  logic                  ovf_clr_i,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic                  wr_inc_o,
   output logic [ADDR_WIDTH:0]   wr_ptr_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic [ADDR_WIDTH:0]   wr_level_o,
   output logic                  overflow_o
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH:0] wbin_q, wbin_d;
   logic [ADDR_WIDTH:0] wgray_q, wgray_d;
   logic [ADDR_WIDTH:0] level_q, level_d;
   logic                full_q, full_d;
   logic                afull_q, afull_d;
   logic [ADDR_WIDTH:0] rq_ptr;
   logic [ADDR_WIDTH:0] rbin_sync;
   logic [ADDR_WIDTH:0] thresh_eff;

   ptr_sync #(
      .WIDTH  (ADDR_WIDTH + 1),
      .STAGES (SYNC_STAGES)
   ) u_rd_ptr_sync (
      .clk_i   (wr_clk_i),
      .arstn_i (wr_arstn_i),
      .d_i     (rd_ptr_i),
      .q_o     (rq_ptr)
   );

   assign wr_inc_o = wr_en_i & ~full_q;

   // Status is computed from the post-write pointer so full asserts on the accepting edge.
   always_comb begin
      wbin_d     = wbin_q + {{ADDR_WIDTH{1'b0}}, wr_inc_o};
      wgray_d    = (ADDR_WIDTH+1)'(bin2gray(PTR_MAX_W'(wbin_d)));
      rbin_sync  = (ADDR_WIDTH+1)'(gray2bin(PTR_MAX_W'(rq_ptr)));
      full_d     = (wgray_d == {~rq_ptr[ADDR_WIDTH:ADDR_WIDTH-1], rq_ptr[ADDR_WIDTH-2:0]});
      level_d    = wbin_d - rbin_sync;
      thresh_eff = (afull_thresh_i > DEPTH_W) ? DEPTH_W : afull_thresh_i;
      afull_d    = (level_d >= thresh_eff);
   end

   always_ff @(posedge wr_clk_i or negedge wr_arstn_i) begin
      if (!wr_arstn_i) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         level_q <= level_d;
         full_q  <= full_d;
         afull_q <= afull_d;
      end
   end

   assign wr_addr_o     = wbin_q[ADDR_WIDTH-1:0];
   assign wr_ptr_o      = wgray_q;
   assign full_o        = full_q;
   assign almost_full_o = afull_q;
   assign wr_level_o    = level_q;

`ifdef WR_PTR_FULL_OVERFLOW_EN
   logic ovf_q, ovf_d;

   // A rejected write in the same cycle as a clear leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr_i) ovf_d = 1'b0;
      if (wr_en_i && full_q) ovf_d = 1'b1;
   end

   always_ff @(posedge wr_clk_i or negedge wr_arstn_i) begin
      if (!wr_arstn_i) ovf_q <= 1'b0;
      else             ovf_q <= ovf_d;
   end

   assign overflow_o = ovf_q;
`else
   logic ovf_clr_unused;
   assign ovf_clr_unused = ovf_clr_i;
   assign overflow_o     = 1'b0;
`endif

endmodule
